// File: rtl/adder_pipelined.sv
// adder_pipelined: add/subtract unit whose carry chain is cut into
// CHUNK-bit slices, one register stage per slice, with valid/ready on both sides.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake for op, input_1, input_2
//   op                   0 = input_1 + input_2, 1 = input_1 - input_2
//   out_valid/out_ready  output handshake for value, borrow
//   value                WIDTH_OUT-bit result (two's complement when SIGNED=1)
//   borrow               unsigned subtract only: input_1 < input_2
module adder_pipelined #(
    parameter int WIDTH_1 = 8,
    parameter int WIDTH_2 = 8,
    parameter int CHUNK = 4,
    parameter int SIGNED = 0,
    localparam int WIDTH_OUT = ((WIDTH_1 > WIDTH_2) ? WIDTH_1 : WIDTH_2) + 1,
    localparam int STAGES = (WIDTH_OUT + CHUNK - 1) / CHUNK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [WIDTH_1-1:0]   input_1,
    input  logic [WIDTH_2-1:0]   input_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] value,
    output logic                 borrow
);

    logic                 advance;
    logic [WIDTH_OUT-1:0] a_ext;
    logic [WIDTH_OUT-1:0] b_ext;
    logic [WIDTH_OUT-1:0] b_op;
    logic                 borrow_q;

    // The whole pipe moves in lockstep; it only stalls when a result
    // is sitting at the output and the consumer is not taking it.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance & ~rst;

    assign a_ext = (SIGNED != 0)
        ? {{(WIDTH_OUT-WIDTH_1){input_1[WIDTH_1-1]}}, input_1}
        : {{(WIDTH_OUT-WIDTH_1){1'b0}}, input_1};
    assign b_ext = (SIGNED != 0)
        ? {{(WIDTH_OUT-WIDTH_2){input_2[WIDTH_2-1]}}, input_2}
        : {{(WIDTH_OUT-WIDTH_2){1'b0}}, input_2};

    // Subtract is A + ~B + 1; the +1 enters as the carry-in of slice 0.
    assign b_op = op ? ~b_ext : b_ext;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int REM = WIDTH_OUT - LO;
        localparam int SW = (REM < CHUNK) ? REM : CHUNK;
        localparam int HW = REM - SW;

        // sa/sb hold only operand bits not yet consumed; bit 0 is
        // the lowest bit of this stage's slice.
        logic [REM-1:0]     sa;
        logic [REM-1:0]     sb;
        logic               sc;
        logic               sop;
        logic               sv;
        logic [SW:0]        sum;
        logic [LO+SW-1:0]   r_d;
        logic [LO+SW-1:0]   r_q;
        logic               v_q;

        if (k == 0) begin : g_head
            assign sa  = a_ext;
            assign sb  = b_op;
            assign sc  = op;
            assign sop = op;
            assign sv  = in_valid;
            assign r_d = sum[SW-1:0];
        end else begin : g_body
            assign sa  = {g_st[k-1].g_fwd.a_q};
            assign sb  = {g_st[k-1].g_fwd.b_q};
            assign sc  = g_st[k-1].g_fwd.c_q;
            assign sop = g_st[k-1].g_fwd.op_q;
            assign sv  = g_st[k-1].v_q;
            assign r_d = {sum[SW-1:0], g_st[k-1].r_q};
        end

        assign sum = {1'b0, sa[SW-1:0]}
                   + {1'b0, sb[SW-1:0]}
                   + {{SW{1'b0}}, sc};

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= sv;
                r_q <= r_d;
            end
        end

        if (HW > 0) begin : g_fwd
            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;
            logic          c_q;
            logic          op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    c_q  <= 1'b0;
                    op_q <= 1'b0;
                end else if (advance) begin
                    c_q  <= sum[SW];
                    op_q <= sop;
                end
            end

            // Pure data; its valid bit travels alongside, so no reset.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= sa[REM-1:SW];
                    b_q <= sb[REM-1:SW];
                end
            end
        end else begin : g_last
            // No carry out of the top slice means the unsigned
            // subtraction wrapped, i.e. input_1 < input_2.
            always_ff @(posedge clk) begin
                if (rst) begin
                    borrow_q <= 1'b0;
                end else if (advance) begin
                    borrow_q <= (SIGNED == 0) && sop && !sum[SW];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign value     = g_st[STAGES-1].r_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// Scoreboard bench for adder_pipelined: three instances (unsigned
// default, signed default, asymmetric 12/5 bits CHUNK=5 signed).
module tb_adder_pipelined;

    localparam int STG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0]       opx;
    logic [2:0]       ov;
    logic [2:0]       ordy;
    logic [2:0]       brw;
    logic [2:0][11:0] a;
    logic [2:0][7:0]  b;
    logic [8:0]       val0;
    logic [8:0]       val1;
    logic [12:0]      val2;
    logic [2:0][12:0] val;

    assign val[0] = {4'b0, val0};
    assign val[1] = {4'b0, val1};
    assign val[2] = val2;

    adder_pipelined u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .op(opx[0]), .input_1(a[0][7:0]), .input_2(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .value(val0),
        .borrow(brw[0])
    );

    adder_pipelined #(.SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .op(opx[1]), .input_1(a[1][7:0]), .input_2(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .value(val1),
        .borrow(brw[1])
    );

    adder_pipelined #(
        .WIDTH_1(12), .WIDTH_2(5), .CHUNK(5), .SIGNED(1)
    ) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .op(opx[2]), .input_1(a[2]), .input_2(b[2][4:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .value(val2),
        .borrow(brw[2])
    );

    typedef struct {
        int          d;
        logic [12:0] v;
        logic        bw;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output handshake pops and checks one entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] === 1'b1 && ordy[d] === 1'b1) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_out dut%0d: got %0h expected none",
                                 d, val[d]);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("value dut%0d", d), 32'(val[d]), 32'(e.v));
                        chk($sformatf("borrow dut%0d", d), 32'(brw[d]), 32'(e.bw));
                        if (e.lat)
                            chk($sformatf("latency dut%0d", d), cyc - e.acc, STG);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [11:0] x,
                        input logic [7:0] y, input logic o,
                        input logic [12:0] ev, input logic eb,
                        input bit lat);
        iv[d]  = 1'b1;
        a[d]   = x;
        b[d]   = y;
        opx[d] = o;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ir[d]) begin
                sb.push_back(exp_t'{d, ev, eb, cyc, lat});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        errors++;
        checks++;
        $display("FAIL accept_timeout dut%0d: got no in_ready expected accept", d);
    endtask

    task automatic idle(input int n);
        iv = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        iv = '0;
        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        iv   = 3'b111;
        opx  = '0;
        a    = '0;
        b    = '0;
        ordy = 3'b111;

        // reset with in_valid held high
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_value", 32'(val0), 0);
        chk("rst_borrow", 32'(brw), 0);
        chk("rst_in_ready", 32'(ir), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv  = '0;
        @(negedge clk);
        chk("rel_in_ready", 32'(ir), 32'h7);
        idle(6);

        // unsigned default
        send(0, 12'd255, 8'd255, 1'b0, 13'h1FE, 1'b0, 1'b1);
        send(0, 12'd3,   8'd5,   1'b1, 13'h1FE, 1'b1, 1'b1);
        send(0, 12'd0,   8'd0,   1'b0, 13'h000, 1'b0, 1'b1);
        send(0, 12'd200, 8'd100, 1'b1, 13'h064, 1'b0, 1'b1);
        send(0, 12'd0,   8'd1,   1'b1, 13'h1FF, 1'b1, 1'b1);
        drain();

        // signed default
        send(1, 12'h80, 8'h80, 1'b0, 13'h100, 1'b0, 1'b1);
        send(1, 12'h7F, 8'h80, 1'b1, 13'h0FF, 1'b0, 1'b1);
        send(1, 12'hFF, 8'hFF, 1'b0, 13'h1FE, 1'b0, 1'b1);
        send(1, 12'h80, 8'h7F, 1'b1, 13'h101, 1'b0, 1'b1);
        drain();

        // asymmetric widths: -2048 + -16 = -2064 = 13'h17F0
        send(2, 12'h800, 8'h10, 1'b0, 13'h17F0, 1'b0, 1'b1);
        send(2, 12'h7FF, 8'h01, 1'b0, 13'h0800, 1'b0, 1'b1);
        send(2, 12'hFFF, 8'h1F, 1'b0, 13'h1FFE, 1'b0, 1'b1);
        send(2, 12'h000, 8'h10, 1'b1, 13'h0010, 1'b0, 1'b1);
        drain();

        // backpressure: 5 back-to-back adds k+k
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        opx[0]  = 1'b0;
        acc     = 0;
        for (int c = 0; c < 40 && acc < 5; c++) begin
            a[0] = 12'(acc + 1);
            b[0] = 8'(acc + 1);
            @(negedge clk);
            if (ir[0]) begin
                sb.push_back(exp_t'{0, 13'(2 * (acc + 1)), 1'b0, cyc, 1'b0});
                acc++;
            end
            if (c >= 3 && c < 8) begin
                chk("stall_out_valid", 32'(ov[0]), 1);
                chk("stall_value", 32'(val0), 2);
                chk("stall_in_ready", 32'(ir[0]), 0);
            end
            @(posedge clk);
            #1;
            if (c == 7) begin
                chk("bp_accepted", acc, 3);
                ordy[0] = 1'b1;
            end
        end
        chk("bp_all_accepted", acc, 5);
        drain();

        // reset while two transactions are in flight
        send(0, 12'd10, 8'd20, 1'b0, 13'h01E, 1'b0, 1'b1);
        idle(4);
        drain();
        send(0, 12'd7, 8'd1, 1'b1, 13'h006, 1'b0, 1'b0);
        send(0, 12'd9, 8'd9, 1'b0, 13'h012, 1'b0, 1'b0);
        iv  = '0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(ir[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 32'(ov[0]), 0);
        chk("mid_value", 32'(val0), 0);
        chk("mid_borrow", 32'(brw[0]), 0);
        chk("mid_in_ready", 32'(ir[0]), 1);
        idle(6);
        send(0, 12'd100, 8'd27, 1'b0, 13'h07F, 1'b0, 1'b1);
        drain();

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
